// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump unit.
//   - state_e      : dump sequencer states
//   - XLEN_DEF     : default register data width
//   - NUM_REGS_DEF : default number of architectural registers walked
package regdump_pkg;

  localparam int unsigned XLEN_DEF     = 64;
  localparam int unsigned NUM_REGS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_unit_if.sv
// Output beat stream of the register-file dump unit (valid/ready handshake).
//   out_valid : beat valid          (master -> slave)
//   out_ready : sink ready          (slave  -> master)
//   out_idx   : register index      (master -> slave)
//   out_data  : register value      (master -> slave)
//   out_last  : final register beat (master -> slave)
interface regfile_dump_unit_if
  import regdump_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned IDX_W = $clog2(NUM_REGS_DEF)
);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [XLEN-1:0]  out_data;
  logic             out_last;

  modport master (
    output out_valid, out_idx, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_idx, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_unit.sv
// Walks an external register file from index 0 to NUM_REGS-1 and emits one
// stream beat per register (index + value) over a valid/ready interface.
// Each register costs a READ cycle (address driven, data captured) followed
// by a HOLD cycle that persists until the sink accepts the beat.
//
// Ports:
//   clk       : clock, rising edge
//   resetn    : asynchronous active-low reset
//   start     : one-cycle dump request, ignored unless idle
//   busy      : high while a dump is in progress
//   done      : one-cycle pulse after the final beat is accepted
//   rf_raddr  : register file read address (0 outside READ)
//   rf_rdata  : combinational register file read data
//   out       : beat stream (regfile_dump_unit_if.master)
//
// Build option: REGDUMP_ZERO_SKIP_EN -- registers holding zero are skipped
// in a single cycle without producing a beat; the final register is always
// emitted so out_last and done are guaranteed.
module regfile_dump_unit
  import regdump_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned IW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IW-1:0]        rf_raddr,
  input  logic [XLEN-1:0]      rf_rdata,
  regfile_dump_unit_if.master  out
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   oidx_q, oidx_d;
  logic [XLEN-1:0] odata_q, odata_d;
  logic            olast_q, olast_d;
  logic            skip;

`ifdef REGDUMP_ZERO_SKIP_EN
  assign skip = (rf_rdata == '0) && (idx_q != LAST_IDX);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      oidx_q  <= '0;
      odata_q <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
      odata_q <= odata_d;
      olast_q <= olast_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    oidx_d        = oidx_q;
    odata_d       = odata_q;
    olast_d       = olast_q;
    busy          = 1'b0;
    done          = 1'b0;
    rf_raddr      = '0;
    out.out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        busy     = 1'b1;
        rf_raddr = idx_q;
        if (skip) begin
          idx_d = idx_q + IW'(1);
        end else begin
          odata_d = rf_rdata;
          oidx_d  = idx_q;
          olast_d = (idx_q == LAST_IDX);
          state_d = HOLD;
        end
      end
      HOLD: begin
        busy          = 1'b1;
        out.out_valid = 1'b1;
        if (out.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = READ;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out.out_idx  = oidx_q;
  assign out.out_data = odata_q;
  // The captured last flag persists after the dump; qualify it with valid so
  // it is only seen on the final beat.
  assign out.out_last = olast_q & out.out_valid;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Self-checking bench for regfile_dump_unit: randomized sink back-pressure
// and register contents, checked against an expected-beat queue derived from
// the register file contents.
module tb_regfile_dump_unit;
  import regdump_pkg::*;

  localparam int unsigned XL = 64;
  localparam int unsigned NR = 32;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          busy;
  logic          done;
  logic [IW-1:0] rf_raddr;
  logic [XL-1:0] rf_rdata;
  logic [XL-1:0] rf [NR];

  regfile_dump_unit_if #(.XLEN(XL), .IDX_W(IW)) ob ();

  regfile_dump_unit #(.XLEN(XL), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .out      (ob)
  );

  always #5 clk = ~clk;
  assign rf_rdata = rf[rf_raddr];

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int n_exp;
  int beats;
  int done_cnt;
  int done_cyc;
  int cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: one beat per register in index order; zero registers dropped
  // when the skip option is built in, except the final register.
  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
`ifdef REGDUMP_ZERO_SKIP_EN
      if (rf[i] == '0 && i < NR - 1) continue;
`endif
      exp_q.push_back(i);
    end
    n_exp    = exp_q.size();
    beats    = 0;
    done_cnt = 0;
    done_cyc = -1;
    cyc      = 0;
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 4) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  // Check the pre-edge beat against the model, advance one clock, then drive
  // the next out_ready value.
  task automatic tick(input int mode);
    if (ob.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 1, 0);
      end else begin
        chk("beat_idx",  64'(ob.out_idx), 64'(exp_q[0]));
        chk("beat_data", ob.out_data, rf[exp_q[0]]);
        chk("beat_last", 64'(ob.out_last), 64'(exp_q[0] == NR - 1));
      end
      chk("raddr_zero", 64'(rf_raddr), 0);
      chk("busy_hold", 64'(busy), 1);
      if (ob.out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        beats++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_fin", 64'(busy), 0);
    end
    ob.out_ready = ready_for(mode, cyc);
  endtask

  task automatic run_dump(input int mode, input int inj_idx);
    bit injected = 0;
    build_exp();
    ob.out_ready = ready_for(mode, 0);
    start = 1'b1;
    tick(mode);
    start = 1'b0;
    chk("busy_start", 64'(busy), 1);
    while (done_cnt == 0 && cyc < 2000) begin
      if (inj_idx >= 0 && !injected && ob.out_valid && int'(ob.out_idx) >= inj_idx) begin
        start    = 1'b1;
        injected = 1;
      end
      tick(mode);
      start = 1'b0;
    end
    chk("done_seen", 64'(done_cnt), 1);
`ifndef REGDUMP_ZERO_SKIP_EN
    if (mode == 0) chk("done_cycle", 64'(done_cyc), 64'(2 * NR + 1));
`endif
    for (int k = 0; k < 4; k++) tick(mode);
    chk("done_once",  64'(done_cnt), 1);
    chk("beat_count", 64'(beats), 64'(n_exp));
    chk("beats_left", 64'(exp_q.size()), 0);
    chk("busy_after", 64'(busy), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(ob.out_valid), 0);
    chk({tag, "_last"},  64'(ob.out_last), 0);
    chk({tag, "_idx"},   64'(ob.out_idx), 0);
    chk({tag, "_data"},  ob.out_data, 0);
    chk({tag, "_raddr"}, 64'(rf_raddr), 0);
    chk({tag, "_busy"},  64'(busy), 0);
    chk({tag, "_done"},  64'(done), 0);
  endtask

  task automatic preload();
    for (int i = 0; i < NR; i++) rf[i] = '0;
    rf[1]  = 64'd5;
    rf[2]  = 64'd7;
    rf[3]  = 64'hFFFF_FFFF_FFFF_FFFD;
    rf[30] = 64'h100;
  endtask

  initial begin
    resetn       = 1'b0;
    start        = 1'b0;
    ob.out_ready = 1'b0;
    preload();
    #2;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Directed register image, sink always ready.
    run_dump(0, -1);
    // Back-pressure 1 on / 3 off.
    run_dump(1, -1);
    // Start pulse mid-dump must be ignored.
    run_dump(2, 5);

    // Reset while a beat around index 10 is pending.
    build_exp();
    ob.out_ready = 1'b1;
    start = 1'b1;
    tick(0);
    start = 1'b0;
    while (!(ob.out_valid && int'(ob.out_idx) >= 10) && cyc < 200) tick(0);
    chk("abort_reached", 64'(ob.out_valid), 1);
    resetn = 1'b0;
    #1;
    chk_outputs_zero("abort");
    @(posedge clk);
    #1;
    chk_outputs_zero("abort_cyc");
    resetn = 1'b1;
    repeat (3) tick(0);
    chk("abort_no_resume", 64'(busy), 0);
    run_dump(0, -1);

    // Sink never ready: first beat held, no completion.
    build_exp();
    ob.out_ready = 1'b0;
    start = 1'b1;
    tick(3);
    start = 1'b0;
    repeat (40) tick(3);
    chk("stall_valid", 64'(ob.out_valid), 1);
    chk("stall_idx",   64'(ob.out_idx), 64'(exp_q[0]));
    chk("stall_busy",  64'(busy), 1);
    chk("stall_done",  64'(done_cnt), 0);
    resetn = 1'b0;
    #1;
    resetn = 1'b1;

    // Random register images with random back-pressure.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++)
        rf[i] = ($urandom_range(0, 2) == 0) ? '0 : {$urandom, $urandom};
      run_dump(2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
